// File: rtl/booth_rr_sched.sv
// Round-robin arbiter sharing one combinational radix-2 signed Booth multiplier
// among NREQ valid/ready requesters; one tagged response port, 3 cycles per op.
module booth_rr_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    busy,
  output logic [15:0]             op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t                   state;
  logic [IDW-1:0]           last_grant;
  logic [IDW-1:0]           id_q;
  logic [IDW-1:0]           winner;
  logic [IDW-1:0]           idx;
  logic                     found;
  logic signed [WIDTH-1:0]  a_q;
  logic signed [WIDTH-1:0]  b_q;
  logic signed [2*WIDTH-1:0] ae;
  logic signed [2*WIDTH-1:0] product;
  logic                     booth_prev;

  // Rotating priority: first valid requester after the last one granted.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found)
      req_ready[winner] = 1'b1;
  end

  // Radix-2 Booth recoding of b_q; a_q is sign-extended so -2^(W-1) squared stays exact.
  always_comb begin
    ae         = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    product    = '0;
    booth_prev = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case ({b_q[i], booth_prev})
        2'b01:   product = product + (ae << i);
        2'b10:   product = product - (ae << i);
        default: product = product;
      endcase
      booth_prev = b_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      op_count    <= '0;
      busy        <= 1'b0;
      last_grant  <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_q        <= req_a[winner*WIDTH +: WIDTH];
            b_q        <= req_b[winner*WIDTH +: WIDTH];
            id_q       <= winner;
            last_grant <= winner;
            state      <= CALC;
            busy       <= 1'b1;
          end
        end
        CALC: begin
          rsp_product <= product;
          rsp_id      <= id_q;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_rr_sched.sv
// Scoreboard bench for booth_rr_sched: directed requests push expected (id, product)
// pairs; a negedge monitor pops and compares on every response handshake.
module tb_booth_rr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic        busy;
  logic [15:0] op_count;

  int passed = 0;
  int total  = 0;
  int pushed = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] p;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  booth_rr_sched #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got id %0d product %h, required no response", rsp_id, rsp_product);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", {30'b0, rsp_id}, {30'b0, mon_e.id});
        check("rsp_product", {16'b0, rsp_product}, {16'b0, mon_e.p});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [15:0] p);
    exp_t e;
    e.id = id[1:0];
    e.p  = p;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
  endtask

  task automatic wait_grant(input string name, input logic [3:0] exp, output int gc);
    int n;
    n = 0;
    @(negedge clk);
    while (!(|(req_valid & req_ready)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    gc = cyc;
    check(name, {28'b0, req_ready}, {28'b0, exp});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("op_count", {16'b0, op_count}, pushed);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pushed = 0;
  endtask

  task automatic corner(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int gc;
    set_op(0, a, b);
    req_valid = 4'b0001;
    push(0, p);
    wait_grant("s3_grant", 4'b0001, gc);
    tick();
    req_valid = '0;
    drain();
  endtask

  initial begin
    int gc, prev, id;
    logic [3:0] m;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_op_count", {16'b0, op_count}, 0);
    check("rst_rsp_id", {30'b0, rsp_id}, 0);
    check("rst_rsp_product", {16'b0, rsp_product}, 0);
    check("rst_req_ready", {28'b0, req_ready}, 0);

    // Single request on requester 2: 7 * -3
    set_op(2, 8'd7, 8'hFD);
    req_valid = 4'b0100;
    push(2, 16'hFFEB);
    #1;
    check("s1_ready", {28'b0, req_ready}, 32'b0100);
    tick();
    req_valid = '0;
    check("s1_busy", {31'b0, busy}, 1);
    check("s1_ready_calc", {28'b0, req_ready}, 0);
    tick();
    check("s1_rsp_valid", {31'b0, rsp_valid}, 1);
    check("s1_rsp_id", {30'b0, rsp_id}, 2);
    tick();
    check("s1_op_count", {16'b0, op_count}, 1);
    check("s1_idle", {31'b0, busy}, 0);

    // All four valid from reset: order 0,1,2,3,0, accepts 3 cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd10);
    for (int i = 0; i < 4; i++) push(i, 16'((i + 1) * 10));
    push(0, 16'd10);
    req_valid = 4'hF;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      m = 4'b0001 << (k % 4);
      wait_grant($sformatf("s2_grant%0d", k), m, gc);
      if (k > 0) check("s2_spacing", gc - prev, 3);
      prev = gc;
    end
    tick();
    req_valid = '0;
    drain();

    // Operand corners on requester 0
    corner(8'h80, 8'h80, 16'h4000);
    corner(8'h80, 8'h7F, 16'hC080);
    corner(8'h00, 8'hFF, 16'h0000);
    corner(8'hFF, 8'hFF, 16'h0001);
    corner(8'h7F, 8'h7F, 16'h3F01);
    corner(8'h80, 8'h01, 16'hFF80);

    // Backpressure: hold the response 5 cycles with another requester waiting
    rsp_ready = 1'b0;
    set_op(3, 8'd5, 8'd6);
    set_op(0, 8'd2, 8'hFE);
    push(3, 16'h001E);
    push(0, 16'hFFFC);
    req_valid = 4'b1001;
    wait_grant("s4_grant3", 4'b1000, gc);
    tick();
    req_valid = 4'b0001;
    tick();
    for (int k = 0; k < 6; k++) begin
      check("s4_hold_valid", {31'b0, rsp_valid}, 1);
      check("s4_hold_id", {30'b0, rsp_id}, 3);
      check("s4_hold_product", {16'b0, rsp_product}, 32'h001E);
      check("s4_hold_ready", {28'b0, req_ready}, 0);
      check("s4_hold_busy", {31'b0, busy}, 1);
      if (k < 5) tick();
    end
    check("s4_op_before", {16'b0, op_count}, pushed - 2);
    rsp_ready = 1'b1;
    tick();
    check("s4_op_after", {16'b0, op_count}, pushed - 1);
    wait_grant("s4_grant0", 4'b0001, gc);
    tick();
    req_valid = '0;
    drain();

    // Fairness: requester 1 held, requester 3 pulsed
    set_op(1, 8'd3, 8'hFC);
    set_op(3, 8'hF9, 8'd9);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      id = (k % 2 == 0) ? 1 : 3;
      push(id, (id == 1) ? 16'hFFF4 : 16'hFFC1);
      m = (id == 1) ? 4'b0010 : 4'b1000;
      wait_grant($sformatf("s5_grant%0d", k), m, gc);
      tick();
      if (id == 3) begin
        req_valid[3] = 1'b0;
        tick();
        if (k != 3) req_valid[3] = 1'b1;
      end
    end
    req_valid = '0;
    drain();

    // Requester 3 raised and dropped while busy must never be granted
    push(1, 16'hFFF4);
    req_valid = 4'b0010;
    wait_grant("s5_skip_grant", 4'b0010, gc);
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    drain();
    repeat (6) tick();
    check("s5_no_spurious_busy", {31'b0, busy}, 0);
    check("s5_no_spurious_ops", {16'b0, op_count}, pushed);

    // Reset during CALC discards the transaction and restores priority
    set_op(1, 8'd4, 8'd4);
    req_valid = 4'b0010;
    wait_grant("s6_grant1", 4'b0010, gc);
    tick();
    req_valid = '0;
    check("s6_in_calc_busy", {31'b0, busy}, 1);
    do_reset();
    check("s6_rsp_valid", {31'b0, rsp_valid}, 0);
    check("s6_busy", {31'b0, busy}, 0);
    check("s6_op_count", {16'b0, op_count}, 0);
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd10);
    push(0, 16'd10);
    req_valid = 4'hF;
    wait_grant("s6_first_grant", 4'b0001, gc);
    tick();
    req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
